// File: rtl/multi_adder_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel flow-controlled adder.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package multi_adder_pkg;

    // Overflow policy, mirrors the integer 'saturate' parameter of the top level
    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } ovf_mode_e;

    // Bits needed to hold the exact sum of n unsigned w-bit operands
    function automatic int full_sum_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    // Pointer width for a FIFO of d entries; never returns zero
    function automatic int ptr_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    // Map the integer build option onto the enum
    function automatic ovf_mode_e ovf_mode(input int sat);
        return (sat != 0) ? SAT : WRAP;
    endfunction

endpackage

// File: rtl/flow_control_fifo.sv
// Small synchronous FIFO with registered full/empty flags and zero-masked head data.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty; flags are pure flops.
module flow_control_fifo
    import multi_adder_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head_data
);

    localparam int               ptr_w    = ptr_width(depth);
    localparam int               cnt_w    = ptr_w + 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // Guard the handshakes with the registered flags so callers cannot corrupt state
    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    // Pointers wrap naturally (depth is a power of two); the count separates full from empty
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == full_cnt);
        empty_d = (cnt_d == '0);
    end

    // Storage write port
    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    // Control state; reset empties the FIFO at once, in-flight data is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the empty flag masks whatever it holds
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign full      = full_q;
    assign empty     = empty_q;
    // Masking keeps the head at zero while empty, so downstream outputs reset cleanly
    assign head_data = empty_q ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/multi_adder_with_flow_control.sv
// Joins n_ch operand streams, adds one operand per channel, emits wrapped or saturated sum.
// Latency: 2 cycles from the last-arriving operand handshake to sum_vld; 1 sum per cycle sustained.
// Backpressure: per-channel FIFOs plus a 2-entry output buffer; in_rdy is a registered not-full.
module multi_adder_with_flow_control
    import multi_adder_pkg::*;
#(
    parameter int width    = 8,
    parameter int n_ch     = 4,
    parameter int depth    = 2,
    parameter int saturate = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [n_ch-1:0]       in_vld,
    output logic [n_ch-1:0]       in_rdy,
    input  logic [n_ch*width-1:0] in_data,
    output logic                  sum_vld,
    input  logic                  sum_rdy,
    output logic [width-1:0]      sum_data,
    output logic                  sum_ovf
);

    localparam int        fs_w  = full_sum_width(width, n_ch);
    localparam int        n_pow = 1 << $clog2(n_ch);
    localparam ovf_mode_e mode  = ovf_mode(saturate);

    logic [n_ch-1:0]  ch_full;
    logic [n_ch-1:0]  ch_empty;
    logic [width-1:0] ch_head [n_ch];
    logic             fire;
    logic [fs_w-1:0]  full_sum;
    logic             sum_ovf_c;
    logic [width-1:0] sum_val;
    logic             out_full;
    logic             out_empty;
    logic [width:0]   out_head;

    // One independent operand FIFO per channel; all are popped together on fire
    genvar k;
    generate
        for (k = 0; k < n_ch; k++) begin : g_ch
            flow_control_fifo #(
                .width (width),
                .depth (depth)
            ) u_in_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (in_vld[k] & ~ch_full[k]),
                .push_data (in_data[k*width +: width]),
                .pop       (fire),
                .full      (ch_full[k]),
                .empty     (ch_empty[k]),
                .head_data (ch_head[k])
            );
        end
    endgenerate

    assign in_rdy = ~ch_full;

    // Join: only registered flags feed fire, so sum_rdy never reaches in_rdy combinationally
    assign fire = ~(|ch_empty) & ~out_full;

    // Balanced adder tree over the FIFO heads; missing leaves (non-power-of-two n_ch) are zero
    always_comb begin : adder_tree
        logic [fs_w-1:0] node [2*n_pow];
        for (int i = 0; i < 2*n_pow; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < n_ch; i++) begin
            node[n_pow+i] = fs_w'(ch_head[i]);
        end
        for (int i = n_pow-1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        full_sum = node[1];
    end

    // Overflow is any carry beyond width bits; saturate mode clamps to all-ones
    always_comb begin
        sum_ovf_c = |full_sum[fs_w-1:width];
        sum_val   = full_sum[width-1:0];
        if (mode == SAT && sum_ovf_c) begin
            sum_val = '1;
        end
    end

    // Output skid buffer: holds {ovf, sum}; its head drives the output stream directly
    flow_control_fifo #(
        .width (width + 1),
        .depth (2)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire),
        .push_data ({sum_ovf_c, sum_val}),
        .pop       (~out_empty & sum_rdy),
        .full      (out_full),
        .empty     (out_empty),
        .head_data (out_head)
    );

    assign sum_vld  = ~out_empty;
    assign sum_data = out_head[width-1:0];
    assign sum_ovf  = out_head[width];

endmodule

// File: doc/multi_adder_with_flow_control.md
# multi_adder_with_flow_control

Parametrised successor to the two-operand flow-controlled adder. It joins `n_ch` valid/ready operand streams, adds one operand from each channel per transaction, and emits the sum on a valid/ready output stream with wrap or saturate overflow handling. Each input channel has its own `depth`-entry FIFO, and the output has a 2-entry buffer, so no combinational path runs from `sum_rdy` to any `in_rdy`. It sits wherever several producers must be combined element-wise into one stream, for example accumulating partial results from parallel lanes.

## Interface
- `width`, 8: operand and sum width in bits, unsigned.
- `n_ch`, 4: number of operand channels, range 2..16.
- `depth`, 2: entries per input FIFO; power of two, minimum 2.
- `saturate`, 0: 0 = sum wraps modulo 2^`width`; 1 = sum clamps to 2^`width`−1.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_vld`  in  `n_ch`  per-channel operand valid.
- `in_rdy`  out  `n_ch`  per-channel ready; registered, equals "FIFO not full".
- `in_data`  in  `n_ch`*`width`  operands, flattened; channel k occupies bits [k*`width` +: `width`].
- `sum_vld`  out  1  output valid.
- `sum_rdy`  in  1  output ready.
- `sum_data`  out  `width`  sum, after wrap or saturate.
- `sum_ovf`  out  1  qualified by `sum_vld`; 1 when the true sum exceeded 2^`width`−1.

## Operation
- **Channel write:** channel k writes its FIFO when `in_vld[k] & in_rdy[k]`. Channels are fully independent and may run ahead of each other by up to `depth` entries.
- **Join fire:** fire = every FIFO is non-empty AND the output buffer is not full. Fire uses only registered state.
  - On fire, one entry is popped from every FIFO in the same cycle.
  - The sum is pushed into the output buffer.
- **Arithmetic:**
  - Full-precision sum uses `width` + $clog2(`n_ch`) bits.
  - `sum_ovf` = (full sum ≥ 2^`width`).
  - Wrap mode: `sum_data` = low `width` bits of the full sum.
  - Saturate mode: `sum_data` = all-ones when `sum_ovf` is set, otherwise the full sum.
  - `sum_ovf` is produced in both modes.
- **Output buffer:** 2-entry FIFO. The head drives `sum_vld`, `sum_data` and `sum_ovf`; the entry pops on `sum_vld & sum_rdy`.
- **Handshake rules:**
  - Once `sum_vld` is asserted, `sum_data` and `sum_ovf` hold stable until accepted.
  - A producer may drop `in_vld` freely.
  - Data is captured only on handshake.
- **Boundaries:**
  - Full input FIFO with a simultaneous pop in the same cycle: `in_rdy` stays low that cycle because it is registered. This is accepted and does not block throughput at `depth` ≥ 2.
  - Full output buffer with a simultaneous pop: fire is blocked that cycle and resumes next cycle.
  - Pointers wrap modulo `depth`; a separate count or extra pointer bit distinguishes full from empty.
- **Reset:** asserting `rst_n` low at any time, including mid-transaction, immediately empties all FIFOs and discards in-flight data.
  - Reset values: `in_rdy` = all-ones, `sum_vld` = 0, `sum_data` = 0, `sum_ovf` = 0.
  - Storage arrays need no reset.

## Timing
- **Latency:** operand accepted at edge N → visible in its FIFO at N+1. If all channels have data, fire occurs in cycle N+1 and `sum_vld` rises after edge N+2. Minimum latency from the last-arriving operand handshake to `sum_vld` is 2 cycles.
- **Throughput:** one sum per cycle sustained when all `in_vld` and `sum_rdy` are held high.
- **Backpressure:** `sum_rdy` low for M cycles:
  - the output buffer fills after 2 fires;
  - each FIFO then fills with `depth` entries;
  - `in_rdy` falls one cycle after its FIFO becomes full.
- **Combinational paths:** none from inputs to outputs. `in_rdy`, `sum_vld`, `sum_data` and `sum_ovf` are register-driven.

## Structure
- **Package `multi_adder_pkg`:**
  - localparam function for the full-sum width;
  - enum `ovf_mode_e` {WRAP, SAT} mirroring `saturate`;
  - a `clog2`-safe pointer-width helper.
- **Sub-module `flow_control_fifo`:** parameters `width` and `depth`; ports push, pop, full, empty, and head data.
  - Instantiated `n_ch` times for the inputs.
  - Instantiated once with `depth`=2 and `width`+1 bits (data + ovf) for the output.
- **Top level:** join logic, adder tree (combinational, one cycle), and overflow mapping live here.

## Test plan
- **Basic sum:** `n_ch`=4, `width`=8, operands 1,2,3,4 all valid in the same cycle, `sum_rdy`=1 → `sum_vld` two cycles later, `sum_data`=10, `sum_ovf`=0.
- **Skewed channels:** channel 3 arrives 5 cycles after channels 0–2 → exactly one sum, 2 cycles after channel 3's handshake. No sum is issued earlier.
- **Overflow:** operands 200,100,0,0.
  - Wrap build → `sum_data`=44, `sum_ovf`=1.
  - Saturate build → `sum_data`=255, `sum_ovf`=1.
  - Operands 255,0,0,0 → 255, `sum_ovf`=0.
- **Backpressure:** stream 20 random vectors with `sum_rdy` low for 10 cycles.
  - Expect `in_rdy` low on all channels.
  - No data loss or duplication.
  - Output order equals reference-model order.
  - 1 sum per cycle after release.
- **Randomised validity:** random `in_vld`/`sum_rdy` duty cycles (30–100%) over 10k transactions → scoreboard match, and stable `sum_data` while `sum_vld & ~sum_rdy`.
- **Mid-operation reset:** `rst_n` driven low while both buffers hold data → next cycle `sum_vld`=0, `in_rdy`=all-ones. After release, the first sum reflects only post-reset operands.
